dual_lsu_port: RTL and testbench
================================

Name: dual_lsu_port

Overview:
- Memory-stage initiator that lets both issue lanes of the 2-way in-order pipeline share the single-port data memory.
- Accepts up to two load/store operations per cycle and serialises them, lane 1 first, onto the memory's read/write/address interface.
- Stalls the pipeline for one cycle when both lanes need memory.
- Returns load data per lane, registered, aligned with the writeback stage.

Parameters:
- DW, 32, data width.
- AW, 32, byte address width.
- RW, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ld1, st1  in  1 each  lane-1 load / store request. Both high is illegal and treated as store.
- adr1  in  AW  lane-1 byte address.
- wdata1  in  DW  lane-1 store data.
- rd1  in  RW  lane-1 load destination.
- ld2, st2, adr2, wdata2, rd2  in  as lane 1  lane-2 request.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_adr  out  AW  memory byte address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data. Combinational, valid in the same cycle as mem_read.
- stall  out  1  pipeline freeze request. Combinational.
- res_valid1, res_valid2  out  1 each  load result valid, per lane.
- res_data1, res_data2  out  DW  load result data.
- res_rd1, res_rd2  out  RW  load result destination.
- align_err  out  1  sticky misaligned-access flag.
- stall_cnt  out  32  count of stall cycles.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high, sampled at posedge clk only.
- Reset values:
  - state IDLE, hold register cleared.
  - All res_* outputs 0; align_err 0; stall_cnt 0.
  - mem_read, mem_write, stall are 0 in any cycle where rst=1.
- Lane "active" = ld or st asserted.
- Lane "valid" = active and adr[1:0]==0.
- An active lane with adr[1:0]!=0:
  - Op is dropped: no memory enable, no result.
  - align_err sets at the next edge and stays set until rst.
- State IDLE:
  - Neither lane valid: all memory enables 0, stall 0.
  - Exactly one lane valid: drive that lane's op combinationally onto mem_*, stall 0, stay IDLE.
  - Both lanes valid:
    - Drive lane 1's op and assert stall this cycle.
    - Capture lane 2's op (ld/st, adr, wdata, rd) into the hold register.
    - Capture lane 1's load data if it is a load.
    - Go to SECOND.
- State SECOND:
  - Drive the held lane-2 op; stall 0. Port inputs are ignored (the pipeline holds them stable anyway).
  - Return to IDLE at the next edge.
  - No new requests are accepted in SECOND.
- Results:
  - Registered, and valid for exactly one cycle.
  - Single-op load issued in cycle t: res_valid/res_data/res_rd of the issuing lane appear at t+1.
  - Dual op issued at t (lane 1) and t+1 (lane 2): both lanes' results appear together at t+2. Lane-1 data is the value captured at t.
  - Stores never raise res_valid.
- Ordering: lane 1 always reaches memory before lane 2. A lane-1 store followed by a lane-2 load to the same address therefore returns the new data. Memory writes commit on the edge ending the issue cycle.
- stall_cnt increments by 1 on every cycle stall=1 and wraps modulo 2^32.
- mem_wdata is 0 when mem_write=0. mem_adr is 0 when no op is issued.
- Reset in SECOND:
  - The held op is discarded and never issued; mem_write=0 that cycle.
  - State returns to IDLE and all results clear.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=1'b0, SECOND=1'b1.
  - A memory-op record constant layout: {ld, st, rd, adr, wdata}.
  - Width constants DW/AW/RW.
- One natural sub-module, lsu_op_hold: the enable-loaded hold register for the deferred lane-2 op, with synchronous clear.

Test Plan:
- Single load: memory word 0x10 = 0xCAFE0001; ld1=1, adr1=0x10, rd1=5 → mem_read=1, mem_adr=0x10 in that cycle, stall=0; next cycle res_valid1=1, res_data1=0xCAFE0001, res_rd1=5.
- Dual loads: ld1 adr 0x20 (=0x11), ld2 adr 0x24 (=0x22), rd 3/4 → stall=1 in cycle t only; mem_adr 0x20 at t, 0x24 at t+1; at t+2 both res_valid=1 with data 0x11/0x22; stall_cnt=1.
- Store then load, same address: st1 adr 0x40 wdata 0xDEADBEEF, ld2 adr 0x40 → mem_write at t, mem_read at t+1; res_data2=0xDEADBEEF at t+2; res_valid1 stays 0.
- Misaligned: ld1 adr 0x13, st2 aligned adr 0x30 → only the lane-2 write is issued, stall=0, align_err=1 from the next cycle until rst.
- Reset mid-op: dual stores to 0x50/0x54, rst=1 in the SECOND cycle → address 0x54 unchanged, state IDLE, stall_cnt=0, all res_valid=0.
- Back-to-back: dual ops in two consecutive instruction pairs → stall pattern 1,0,1,0; stall_cnt=2; four results, in lane order.

Source files
------------

// File: rtl/dual_lsu_port_pkg.sv
// Shared types for the dual-lane load/store port: FSM state, the memory-op record
// and the default data/address/register-index widths.
package dual_lsu_port_pkg;

    localparam int LSU_DW = 32;
    localparam int LSU_AW = 32;
    localparam int LSU_RW = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_e;

    typedef struct packed {
        logic              ld;
        logic              st;
        logic [LSU_RW-1:0] rd;
        logic [LSU_AW-1:0] adr;
        logic [LSU_DW-1:0] wdata;
    } mem_op_t;

    // ld+st together resolves to a store; unused fields are zeroed so the
    // record can be driven straight onto the memory bus.
    function automatic mem_op_t make_op(
        input logic              ld,
        input logic              st,
        input logic [LSU_RW-1:0] rd,
        input logic [LSU_AW-1:0] adr,
        input logic [LSU_DW-1:0] wdata
    );
        mem_op_t op;
        op.ld    = ld & ~st;
        op.st    = st;
        op.rd    = (ld & ~st) ? rd : '0;
        op.adr   = adr;
        op.wdata = st ? wdata : '0;
        return op;
    endfunction

    function automatic logic word_aligned(input logic [LSU_AW-1:0] adr);
        return (adr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_op_hold.sv
// Enable-loaded hold register for the deferred lane-2 memory op, with
// synchronous clear so a discarded op can never be reissued.
module lsu_op_hold
    import dual_lsu_port_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  logic    i_clr,
    input  mem_op_t i_op,
    output mem_op_t o_op
);

    mem_op_t r_op;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_op <= '0;
        end else if (i_load) begin
            r_op <= i_op;
        end
    end

    assign o_op = r_op;

endmodule

// File: rtl/dual_lsu_port.sv
// Memory-stage initiator: serialises up to two lane ops per cycle onto a
// single-port data memory, lane 1 first, and returns registered load results.
module dual_lsu_port
    import dual_lsu_port_pkg::*;
#(
    parameter int DW = LSU_DW,
    parameter int AW = LSU_AW,
    parameter int RW = LSU_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld1,
    input  logic          st1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata1,
    input  logic [RW-1:0] rd1,
    input  logic          ld2,
    input  logic          st2,
    input  logic [AW-1:0] adr2,
    input  logic [DW-1:0] wdata2,
    input  logic [RW-1:0] rd2,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          res_valid1,
    output logic          res_valid2,
    output logic [DW-1:0] res_data1,
    output logic [DW-1:0] res_data2,
    output logic [RW-1:0] res_rd1,
    output logic [RW-1:0] res_rd2,
    output logic          align_err,
    output logic [31:0]   stall_cnt
);

    lsu_state_e    r_state;
    logic          r_l1_vld;
    logic [DW-1:0] r_l1_data;
    logic [RW-1:0] r_l1_rd;

    mem_op_t w_op1;
    mem_op_t w_op2;
    mem_op_t w_held;
    mem_op_t w_issue;
    logic    w_act1;
    logic    w_act2;
    logic    w_val1;
    logic    w_val2;
    logic    w_idle;
    logic    w_second;
    logic    w_dual;
    logic    w_misalign;

    assign w_op1  = make_op(ld1, st1, rd1, adr1, wdata1);
    assign w_op2  = make_op(ld2, st2, rd2, adr2, wdata2);
    assign w_act1 = ld1 | st1;
    assign w_act2 = ld2 | st2;
    assign w_val1 = w_act1 & word_aligned(adr1);
    assign w_val2 = w_act2 & word_aligned(adr2);

    // Requests are only looked at in IDLE; while SECOND runs the pipeline is
    // replaying the same pair and must not be re-accepted.
    assign w_idle     = (r_state == ST_IDLE) & ~rst;
    assign w_second   = (r_state == ST_SECOND) & ~rst;
    assign w_dual     = w_idle & w_val1 & w_val2;
    assign w_misalign = w_idle & ((w_act1 & ~w_val1) | (w_act2 & ~w_val2));

    lsu_op_hold u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_dual),
        .i_clr  (r_state == ST_SECOND),
        .i_op   (w_op2),
        .o_op   (w_held)
    );

    always_comb begin
        w_issue = '0;
        if (w_second) begin
            w_issue = w_held;
        end else if (w_idle && w_val1) begin
            w_issue = w_op1;
        end else if (w_idle && w_val2) begin
            w_issue = w_op2;
        end
    end

    assign mem_read  = w_issue.ld;
    assign mem_write = w_issue.st;
    assign mem_adr   = (w_issue.ld | w_issue.st) ? w_issue.adr : '0;
    assign mem_wdata = w_issue.wdata;
    assign stall     = w_dual;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_l1_vld   <= 1'b0;
            r_l1_data  <= '0;
            r_l1_rd    <= '0;
            res_valid1 <= 1'b0;
            res_valid2 <= 1'b0;
            res_data1  <= '0;
            res_data2  <= '0;
            res_rd1    <= '0;
            res_rd2    <= '0;
            align_err  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            res_valid1 <= 1'b0;
            res_valid2 <= 1'b0;
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (w_misalign) begin
                align_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_dual) begin
                        // Lane-1 load data is only on the bus now; keep it so
                        // both lanes can retire together after the second op.
                        r_l1_vld  <= w_op1.ld;
                        r_l1_data <= mem_rdata;
                        r_l1_rd   <= w_op1.rd;
                        r_state   <= ST_SECOND;
                    end else if (w_val1) begin
                        if (w_op1.ld) begin
                            res_valid1 <= 1'b1;
                            res_data1  <= mem_rdata;
                            res_rd1    <= w_op1.rd;
                        end
                    end else if (w_val2) begin
                        if (w_op2.ld) begin
                            res_valid2 <= 1'b1;
                            res_data2  <= mem_rdata;
                            res_rd2    <= w_op2.rd;
                        end
                    end
                end
                ST_SECOND: begin
                    if (r_l1_vld) begin
                        res_valid1 <= 1'b1;
                        res_data1  <= r_l1_data;
                        res_rd1    <= r_l1_rd;
                    end
                    if (w_held.ld) begin
                        res_valid2 <= 1'b1;
                        res_data2  <= mem_rdata;
                        res_rd2    <= w_held.rd;
                    end
                    r_l1_vld <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_lsu_port.sv
// Directed bench for dual_lsu_port with a small word-addressed memory model.
module tb_dual_lsu_port;

    logic        clk;
    logic        rst;
    logic        ld1, st1, ld2, st2;
    logic [31:0] adr1, adr2, wdata1, wdata2;
    logic [4:0]  rd1, rd2;
    logic        mem_read, mem_write;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        stall;
    logic        res_valid1, res_valid2;
    logic [31:0] res_data1, res_data2;
    logic [4:0]  res_rd1, res_rd2;
    logic        align_err;
    logic [31:0] stall_cnt;

    logic [31:0] mem [0:63];
    int          nchk;
    int          nfail;

    dual_lsu_port dut (
        .clk        (clk),
        .rst        (rst),
        .ld1        (ld1),
        .st1        (st1),
        .adr1       (adr1),
        .wdata1     (wdata1),
        .rd1        (rd1),
        .ld2        (ld2),
        .st2        (st2),
        .adr2       (adr2),
        .wdata2     (wdata2),
        .rd2        (rd2),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .res_valid1 (res_valid1),
        .res_valid2 (res_valid2),
        .res_data1  (res_data1),
        .res_data2  (res_data2),
        .res_rd1    (res_rd1),
        .res_rd2    (res_rd2),
        .align_err  (align_err),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_adr[7:2]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ld1 = 1'b0; st1 = 1'b0; adr1 = '0; wdata1 = '0; rd1 = '0;
        ld2 = 1'b0; st2 = 1'b0; adr2 = '0; wdata2 = '0; rd2 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld1 = 1'b1; adr1 = 32'h10; rd1 = 5'd1;
        ld2 = 1'b1; adr2 = 32'h14; rd2 = 5'd2;
        @(negedge clk);
        nchk++; if (mem_read !== 1'b0) begin nfail++; $display("FAIL reset_mem_read: got %h expected 0", mem_read); end
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL reset_stall: got %h expected 0", stall); end
        tick();
        tick();
        nchk++; if (res_valid1 !== 1'b0 || res_valid2 !== 1'b0) begin nfail++; $display("FAIL reset_res_valid: got %b%b expected 00", res_valid1, res_valid2); end
        nchk++; if (res_data1 !== 32'h0 || res_rd1 !== 5'h0) begin nfail++; $display("FAIL reset_res1: got %h/%h expected 0/0", res_data1, res_rd1); end
        nchk++; if (align_err !== 1'b0) begin nfail++; $display("FAIL reset_align_err: got %h expected 0", align_err); end
        nchk++; if (stall_cnt !== 32'd0) begin nfail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        rst = 1'b0;
        set_idle();
        tick();
    endtask

    task automatic test_single_load();
        ld1 = 1'b1; adr1 = 32'h10; rd1 = 5'd5;
        @(negedge clk);
        nchk++; if (mem_read !== 1'b1) begin nfail++; $display("FAIL single_mem_read: got %h expected 1", mem_read); end
        nchk++; if (mem_adr !== 32'h10) begin nfail++; $display("FAIL single_mem_adr: got %h expected 00000010", mem_adr); end
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL single_stall: got %h expected 0", stall); end
        nchk++; if (mem_write !== 1'b0 || mem_wdata !== 32'h0) begin nfail++; $display("FAIL single_no_write: got %h/%h expected 0/0", mem_write, mem_wdata); end
        tick();
        set_idle();
        nchk++; if (res_valid1 !== 1'b1) begin nfail++; $display("FAIL single_res_valid1: got %h expected 1", res_valid1); end
        nchk++; if (res_data1 !== 32'hCAFE0001) begin nfail++; $display("FAIL single_res_data1: got %h expected cafe0001", res_data1); end
        nchk++; if (res_rd1 !== 5'd5) begin nfail++; $display("FAIL single_res_rd1: got %0d expected 5", res_rd1); end
        nchk++; if (res_valid2 !== 1'b0) begin nfail++; $display("FAIL single_res_valid2: got %h expected 0", res_valid2); end
        @(negedge clk);
        nchk++; if (mem_read !== 1'b0 || mem_adr !== 32'h0) begin nfail++; $display("FAIL single_idle_bus: got %h/%h expected 0/0", mem_read, mem_adr); end
        tick();
        nchk++; if (res_valid1 !== 1'b0) begin nfail++; $display("FAIL single_one_cycle: got %h expected 0", res_valid1); end
    endtask

    task automatic test_dual_loads();
        ld1 = 1'b1; adr1 = 32'h20; rd1 = 5'd3;
        ld2 = 1'b1; adr2 = 32'h24; rd2 = 5'd4;
        @(negedge clk);
        nchk++; if (stall !== 1'b1) begin nfail++; $display("FAIL dual_stall_t: got %h expected 1", stall); end
        nchk++; if (mem_read !== 1'b1 || mem_adr !== 32'h20) begin nfail++; $display("FAIL dual_bus_t: got %h/%h expected 1/00000020", mem_read, mem_adr); end
        tick();
        nchk++; if (res_valid1 !== 1'b0 || res_valid2 !== 1'b0) begin nfail++; $display("FAIL dual_early_res: got %b%b expected 00", res_valid1, res_valid2); end
        @(negedge clk);
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL dual_stall_t1: got %h expected 0", stall); end
        nchk++; if (mem_read !== 1'b1 || mem_adr !== 32'h24) begin nfail++; $display("FAIL dual_bus_t1: got %h/%h expected 1/00000024", mem_read, mem_adr); end
        tick();
        set_idle();
        nchk++; if (res_valid1 !== 1'b1 || res_data1 !== 32'h11 || res_rd1 !== 5'd3) begin nfail++; $display("FAIL dual_res1: got %h/%h/%0d expected 1/00000011/3", res_valid1, res_data1, res_rd1); end
        nchk++; if (res_valid2 !== 1'b1 || res_data2 !== 32'h22 || res_rd2 !== 5'd4) begin nfail++; $display("FAIL dual_res2: got %h/%h/%0d expected 1/00000022/4", res_valid2, res_data2, res_rd2); end
        nchk++; if (stall_cnt !== 32'd1) begin nfail++; $display("FAIL dual_stall_cnt: got %0d expected 1", stall_cnt); end
        tick();
    endtask

    task automatic test_store_then_load();
        st1 = 1'b1; adr1 = 32'h40; wdata1 = 32'hDEADBEEF;
        ld2 = 1'b1; adr2 = 32'h40; rd2 = 5'd7;
        @(negedge clk);
        nchk++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin nfail++; $display("FAIL stld_write_t: got w%h r%h expected w1 r0", mem_write, mem_read); end
        nchk++; if (mem_wdata !== 32'hDEADBEEF || mem_adr !== 32'h40) begin nfail++; $display("FAIL stld_wbus_t: got %h@%h expected deadbeef@00000040", mem_wdata, mem_adr); end
        tick();
        @(negedge clk);
        nchk++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_adr !== 32'h40) begin nfail++; $display("FAIL stld_read_t1: got r%h w%h a%h expected r1 w0 a00000040", mem_read, mem_write, mem_adr); end
        nchk++; if (mem_wdata !== 32'h0) begin nfail++; $display("FAIL stld_wdata_zero: got %h expected 0", mem_wdata); end
        tick();
        set_idle();
        nchk++; if (res_valid2 !== 1'b1 || res_data2 !== 32'hDEADBEEF || res_rd2 !== 5'd7) begin nfail++; $display("FAIL stld_res2: got %h/%h/%0d expected 1/deadbeef/7", res_valid2, res_data2, res_rd2); end
        nchk++; if (res_valid1 !== 1'b0) begin nfail++; $display("FAIL stld_res_valid1: got %h expected 0", res_valid1); end
        nchk++; if (stall_cnt !== 32'd2) begin nfail++; $display("FAIL stld_stall_cnt: got %0d expected 2", stall_cnt); end
        tick();
    endtask

    task automatic test_misaligned();
        ld1 = 1'b1; adr1 = 32'h13; rd1 = 5'd9;
        st2 = 1'b1; adr2 = 32'h30; wdata2 = 32'h12345678;
        @(negedge clk);
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL mis_stall: got %h expected 0", stall); end
        nchk++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_adr !== 32'h30) begin nfail++; $display("FAIL mis_bus: got w%h r%h a%h expected w1 r0 a00000030", mem_write, mem_read, mem_adr); end
        nchk++; if (align_err !== 1'b0) begin nfail++; $display("FAIL mis_align_early: got %h expected 0", align_err); end
        tick();
        set_idle();
        nchk++; if (align_err !== 1'b1) begin nfail++; $display("FAIL mis_align_set: got %h expected 1", align_err); end
        nchk++; if (res_valid1 !== 1'b0) begin nfail++; $display("FAIL mis_no_result: got %h expected 0", res_valid1); end
        nchk++; if (mem[12] !== 32'h12345678) begin nfail++; $display("FAIL mis_store_commit: got %h expected 12345678", mem[12]); end
        tick();
        tick();
        nchk++; if (align_err !== 1'b1) begin nfail++; $display("FAIL mis_align_sticky: got %h expected 1", align_err); end
    endtask

    task automatic test_reset_mid_op();
        st1 = 1'b1; adr1 = 32'h50; wdata1 = 32'h00000001;
        st2 = 1'b1; adr2 = 32'h54; wdata2 = 32'h00000002;
        @(negedge clk);
        nchk++; if (stall !== 1'b1 || mem_write !== 1'b1) begin nfail++; $display("FAIL rmid_first: got s%h w%h expected s1 w1", stall, mem_write); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        nchk++; if (mem_write !== 1'b0 || stall !== 1'b0) begin nfail++; $display("FAIL rmid_suppress: got w%h s%h expected w0 s0", mem_write, stall); end
        tick();
        rst = 1'b0;
        set_idle();
        nchk++; if (mem[21] !== 32'hAAAA5555) begin nfail++; $display("FAIL rmid_mem54: got %h expected aaaa5555", mem[21]); end
        nchk++; if (mem[20] !== 32'h00000001) begin nfail++; $display("FAIL rmid_mem50: got %h expected 00000001", mem[20]); end
        nchk++; if (stall_cnt !== 32'd0 || align_err !== 1'b0) begin nfail++; $display("FAIL rmid_counters: got %0d/%h expected 0/0", stall_cnt, align_err); end
        nchk++; if (res_valid1 !== 1'b0 || res_valid2 !== 1'b0) begin nfail++; $display("FAIL rmid_res_valid: got %b%b expected 00", res_valid1, res_valid2); end
        ld1 = 1'b1; adr1 = 32'h54; rd1 = 5'd6;
        @(negedge clk);
        nchk++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_adr !== 32'h54) begin nfail++; $display("FAIL rmid_idle_state: got r%h w%h a%h expected r1 w0 a00000054", mem_read, mem_write, mem_adr); end
        tick();
        set_idle();
        nchk++; if (res_valid1 !== 1'b1 || res_data1 !== 32'hAAAA5555) begin nfail++; $display("FAIL rmid_readback: got %h/%h expected 1/aaaa5555", res_valid1, res_data1); end
        tick();
    endtask

    task automatic test_back_to_back();
        ld1 = 1'b1; adr1 = 32'h20; rd1 = 5'd1;
        ld2 = 1'b1; adr2 = 32'h24; rd2 = 5'd2;
        @(negedge clk);
        nchk++; if (stall !== 1'b1) begin nfail++; $display("FAIL b2b_stall0: got %h expected 1", stall); end
        tick();
        @(negedge clk);
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL b2b_stall1: got %h expected 0", stall); end
        tick();
        nchk++; if (res_valid1 !== 1'b1 || res_data1 !== 32'h11 || res_rd1 !== 5'd1) begin nfail++; $display("FAIL b2b_a_res1: got %h/%h/%0d expected 1/00000011/1", res_valid1, res_data1, res_rd1); end
        nchk++; if (res_valid2 !== 1'b1 || res_data2 !== 32'h22 || res_rd2 !== 5'd2) begin nfail++; $display("FAIL b2b_a_res2: got %h/%h/%0d expected 1/00000022/2", res_valid2, res_data2, res_rd2); end
        ld1 = 1'b1; adr1 = 32'h10; rd1 = 5'd3;
        ld2 = 1'b1; adr2 = 32'h40; rd2 = 5'd4;
        @(negedge clk);
        nchk++; if (stall !== 1'b1 || mem_adr !== 32'h10) begin nfail++; $display("FAIL b2b_stall2: got s%h a%h expected s1 a00000010", stall, mem_adr); end
        tick();
        nchk++; if (res_valid1 !== 1'b0 || res_valid2 !== 1'b0) begin nfail++; $display("FAIL b2b_gap: got %b%b expected 00", res_valid1, res_valid2); end
        @(negedge clk);
        nchk++; if (stall !== 1'b0 || mem_adr !== 32'h40) begin nfail++; $display("FAIL b2b_stall3: got s%h a%h expected s0 a00000040", stall, mem_adr); end
        tick();
        set_idle();
        nchk++; if (res_valid1 !== 1'b1 || res_data1 !== 32'hCAFE0001 || res_rd1 !== 5'd3) begin nfail++; $display("FAIL b2b_b_res1: got %h/%h/%0d expected 1/cafe0001/3", res_valid1, res_data1, res_rd1); end
        nchk++; if (res_valid2 !== 1'b1 || res_data2 !== 32'hDEADBEEF || res_rd2 !== 5'd4) begin nfail++; $display("FAIL b2b_b_res2: got %h/%h/%0d expected 1/deadbeef/4", res_valid2, res_data2, res_rd2); end
        nchk++; if (stall_cnt !== 32'd2) begin nfail++; $display("FAIL b2b_stall_cnt: got %0d expected 2", stall_cnt); end
        tick();
    endtask

    initial begin
        nchk  = 0;
        nfail = 0;
        rst   = 1'b1;
        set_idle();
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[4]  <= 32'hCAFE0001;
        mem[8]  <= 32'h00000011;
        mem[9]  <= 32'h00000022;
        mem[21] <= 32'hAAAA5555;
        #1;
        test_reset();
        test_single_load();
        test_dual_loads();
        test_store_then_load();
        test_misaligned();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
